// File: rtl/mipspipe_pkg.sv
// -----------------------------------------------------------------------------
// mipspipe_pkg
// Shared definitions for the MIPS pipeline memory arbiter:
//   - arb_state_e : arbiter FSM state encoding (IDLE / BUSY_I / BUSY_D)
//   - DEF_AW/DEF_DW : default address / data widths
//   - STARVE_CNT_W  : width of the fetch-starvation counter
// No ports (package).
// -----------------------------------------------------------------------------
package mipspipe_pkg;

  localparam int unsigned DEF_AW       = 32;
  localparam int unsigned DEF_DW       = 32;
  localparam int unsigned STARVE_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_e;

endpackage : mipspipe_pkg

// File: rtl/mipspipe_memarb_prio.sv
// -----------------------------------------------------------------------------
// mipspipe_memarb_prio
// Tie-break decision between instruction fetch and data access, plus the
// fetch-starvation counter.
//
// Optional feature macro: MIPSPIPE_MEMARB_STARVE_GUARD_EN
//   defined   : after STARVE_MAX consecutive data grants made while a fetch
//               was waiting, a tie goes to the fetch; any fetch grant clears
//               the count.
//   undefined : data always wins ties; no counter is built.
//
// Ports:
//   i_clock    : clock (rising edge)
//   i_reset    : synchronous active-high reset
//   i_arb_en   : arbiter is in IDLE and may issue a grant this cycle
//   i_if_req   : instruction-fetch request
//   i_dm_req   : data-access request
//   o_grant_i  : fetch granted this cycle (only while i_arb_en)
//   o_grant_d  : data granted this cycle (only while i_arb_en)
// -----------------------------------------------------------------------------
module mipspipe_memarb_prio
  import mipspipe_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_arb_en,
  input  logic i_if_req,
  input  logic i_dm_req,
  output logic o_grant_i,
  output logic o_grant_d
);

  logic w_fetch_wins;

`ifdef MIPSPIPE_MEMARB_STARVE_GUARD_EN
  localparam logic [STARVE_CNT_W-1:0] LP_STARVE_MAX = STARVE_CNT_W'(STARVE_MAX);
  localparam logic [STARVE_CNT_W-1:0] LP_CNT_SAT    = {STARVE_CNT_W{1'b1}};

  logic [STARVE_CNT_W-1:0] r_starve_cnt;
  logic                    w_starved;

  // Fetch wins when it is alone, or when it has been passed over too often.
  always_comb begin
    w_starved = (r_starve_cnt >= LP_STARVE_MAX);
    if (i_if_req && (!i_dm_req || w_starved)) begin
      w_fetch_wins = 1'b1;
    end else begin
      w_fetch_wins = 1'b0;
    end
  end

  // Count data grants made while a fetch waits; saturate rather than wrap.
  // A data grant with no fetch waiting breaks the run, so the count restarts.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_starve_cnt <= {STARVE_CNT_W{1'b0}};
    end else if (o_grant_i) begin
      r_starve_cnt <= {STARVE_CNT_W{1'b0}};
    end else if (o_grant_d) begin
      if (!i_if_req) begin
        r_starve_cnt <= {STARVE_CNT_W{1'b0}};
      end else if (r_starve_cnt != LP_CNT_SAT) begin
        r_starve_cnt <= r_starve_cnt + {{(STARVE_CNT_W-1){1'b0}}, 1'b1};
      end else begin
        r_starve_cnt <= r_starve_cnt;
      end
    end else begin
      r_starve_cnt <= r_starve_cnt;
    end
  end
`else
  // Without the guard the clock, reset and STARVE_MAX have no consumer.
  logic w_unused;
  assign w_unused = ^{i_clock, i_reset, STARVE_CNT_W'(STARVE_MAX)};

  // Data always wins a tie; fetch wins only when alone.
  always_comb begin
    if (i_if_req && !i_dm_req) begin
      w_fetch_wins = 1'b1;
    end else begin
      w_fetch_wins = 1'b0;
    end
  end
`endif

  // Grants are only issued while the arbiter is idle.
  always_comb begin
    if (i_arb_en) begin
      o_grant_i = w_fetch_wins;
      o_grant_d = i_dm_req & ~w_fetch_wins;
    end else begin
      o_grant_i = 1'b0;
      o_grant_d = 1'b0;
    end
  end

endmodule : mipspipe_memarb_prio

// File: rtl/mipspipe_memarb.sv
// -----------------------------------------------------------------------------
// mipspipe_memarb
// Arbitrates a single memory port between the instruction-fetch and the
// data-access stage of a MIPS pipeline. One transaction at a time:
// IDLE -> BUSY_I/BUSY_D -> (mem_ready) -> IDLE, with the requester's ack
// pulsing in the IDLE cycle that follows completion.
//
// Optional feature macro: MIPSPIPE_MEMARB_STARVE_GUARD_EN (fetch starvation
// guard, see mipspipe_memarb_prio).
//
// Parameters: AW address width, DW data width, STARVE_MAX (1-15) data grants
// in a row after which a waiting fetch wins a tie.
//
// Ports:
//   clock, reset                 : clock, synchronous active-high reset
//   if_req/if_addr               : fetch request in
//   if_rdata/if_ack              : fetch read data / one-cycle ack out
//   dm_req/dm_we/dm_addr/dm_wdata: data request in
//   dm_rdata/dm_ack              : data read data / one-cycle ack out
//   mem_en/mem_we/mem_addr/mem_wdata : memory request out (registered)
//   mem_rdata/mem_ready          : memory response in
//   stall_if                     : freeze PC and IF/ID
//   stall_mem                    : freeze EX/MEM and everything upstream
// -----------------------------------------------------------------------------
module mipspipe_memarb
  import mipspipe_pkg::*;
#(
  parameter int unsigned AW         = DEF_AW,
  parameter int unsigned DW         = DEF_DW,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ack,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          stall_if,
  output logic          stall_mem
);

  arb_state_e    r_state;
  arb_state_e    w_state_nxt;
  logic          w_arb_en;
  logic          w_grant_i;
  logic          w_grant_d;
  logic          w_done_i;
  logic          w_done_d;
  logic          r_mem_en;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_dm_rdata;
  logic          r_if_ack;
  logic          r_dm_ack;

  mipspipe_memarb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .i_clock   (clock),
    .i_reset   (reset),
    .i_arb_en  (w_arb_en),
    .i_if_req  (if_req),
    .i_dm_req  (dm_req),
    .o_grant_i (w_grant_i),
    .o_grant_d (w_grant_d)
  );

  // FSM state register; reset abandons any in-flight transaction.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_d) begin
          w_state_nxt = BUSY_D;
        end else if (w_grant_i) begin
          w_state_nxt = BUSY_I;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      BUSY_I: begin
        if (mem_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = BUSY_I;
        end
      end
      BUSY_D: begin
        if (mem_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = BUSY_D;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // FSM output decode: mem_ready only matters in a BUSY state.
  always_comb begin
    w_arb_en = 1'b0;
    w_done_i = 1'b0;
    w_done_d = 1'b0;
    case (r_state)
      IDLE: begin
        w_arb_en = 1'b1;
      end
      BUSY_I: begin
        w_done_i = mem_ready;
      end
      BUSY_D: begin
        w_done_d = mem_ready;
      end
      default: begin
        w_arb_en = 1'b0;
      end
    endcase
  end

  // Request latches, read-data capture and ack pulses.
  // mem_addr/mem_wdata keep their last value after completion; only mem_en
  // and mem_we drop, so the memory sees no stray write.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= {AW{1'b0}};
      r_mem_wdata <= {DW{1'b0}};
      r_if_rdata  <= {DW{1'b0}};
      r_dm_rdata  <= {DW{1'b0}};
      r_if_ack    <= 1'b0;
      r_dm_ack    <= 1'b0;
    end else begin
      r_mem_en <= (w_state_nxt != IDLE);
      r_if_ack <= w_done_i;
      r_dm_ack <= w_done_d;
      if (w_grant_d) begin
        r_mem_addr  <= dm_addr;
        r_mem_we    <= dm_we;
        r_mem_wdata <= dm_wdata;
      end else if (w_grant_i) begin
        r_mem_addr  <= if_addr;
        r_mem_we    <= 1'b0;
        r_mem_wdata <= {DW{1'b0}};
      end else if (w_done_i || w_done_d) begin
        r_mem_we    <= 1'b0;
      end
      if (w_done_i) begin
        r_if_rdata <= mem_rdata;
      end
      if (w_done_d) begin
        r_dm_rdata <= mem_rdata;
      end
    end
  end

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign if_ack    = r_if_ack;
  assign dm_ack    = r_dm_ack;

  // A requester that has dropped its request is never stalled.
  assign stall_if  = if_req & ~r_if_ack;
  assign stall_mem = dm_req & ~r_dm_ack;

endmodule : mipspipe_memarb

// File: tb/tb_mipspipe_memarb.sv
// -----------------------------------------------------------------------------
// tb_mipspipe_memarb
// Directed scenarios followed by randomized traffic, all checked against a
// transaction-level reference model of the arbiter.
// Honours MIPSPIPE_MEMARB_STARVE_GUARD_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_mipspipe_memarb;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SM = 3;
`ifdef MIPSPIPE_MEMARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ack;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;
  logic          stall_if;
  logic          stall_mem;

  always #5 clock = ~clock;

  mipspipe_memarb #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: the single outstanding transaction plus response regs.
  bit            m_act;
  bit            m_is_data;
  logic [AW-1:0] m_addr;
  bit            m_we;
  logic [DW-1:0] m_wdata;
  bit            m_if_ack;
  bit            m_dm_ack;
  logic [DW-1:0] m_if_rdata;
  logic [DW-1:0] m_dm_rdata;
  int            m_cnt;

  logic          prev_en;
  logic [63:0]   grant_log;
  int            ack_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at the edge.
  task automatic model_edge();
    bit fetch_first;
    if (reset) begin
      m_act = 1'b0; m_is_data = 1'b0; m_addr = '0; m_we = 1'b0; m_wdata = '0;
      m_if_ack = 1'b0; m_dm_ack = 1'b0; m_if_rdata = '0; m_dm_rdata = '0;
      m_cnt = 0;
    end else begin
      m_if_ack = 1'b0;
      m_dm_ack = 1'b0;
      if (m_act) begin
        if (mem_ready) begin
          m_act = 1'b0;
          m_we  = 1'b0;
          if (m_is_data) begin m_dm_ack = 1'b1; m_dm_rdata = mem_rdata; end
          else           begin m_if_ack = 1'b1; m_if_rdata = mem_rdata; end
        end
      end else if (if_req || dm_req) begin
        fetch_first = if_req && (!dm_req || (GUARD && m_cnt >= SM));
        m_act = 1'b1;
        if (fetch_first) begin
          m_is_data = 1'b0; m_addr = if_addr; m_we = 1'b0; m_wdata = '0;
          m_cnt = 0;
        end else begin
          m_is_data = 1'b1; m_addr = dm_addr; m_we = dm_we; m_wdata = dm_wdata;
          m_cnt = if_req ? ((m_cnt < 15) ? m_cnt + 1 : 15) : 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("mem_en",    mem_en,    m_act);
    chk("mem_we",    mem_we,    m_act & m_we);
    chk("mem_addr",  mem_addr,  m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("if_ack",    if_ack,    m_if_ack);
    chk("dm_ack",    dm_ack,    m_dm_ack);
    chk("if_rdata",  if_rdata,  m_if_rdata);
    chk("dm_rdata",  dm_rdata,  m_dm_rdata);
    chk("stall_if",  stall_if,  if_req & ~m_if_ack);
    chk("stall_mem", stall_mem, dm_req & ~m_dm_ack);
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    compare_all();
    if (mem_en && !prev_en)
      grant_log = {grant_log[55:0], (mem_addr == 32'h0000_0100) ? 8'h44 : 8'h49};
    if (dm_ack) ack_cnt++;
    prev_en = mem_en;
  endtask

  initial begin
    reset = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    prev_en = 1'b0; grant_log = '0; ack_cnt = 0;
    tick(); tick();
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_acks", {if_ack, dm_ack}, 2'b00);
    chk("rst_rdata", {if_rdata, dm_rdata}, 64'h0);
    reset = 1'b0;
    tick();

    // Fetch only, memory ready immediately.
    if_req = 1'b1; if_addr = 32'h0000_0010; mem_ready = 1'b1; mem_rdata = 32'hCAFE_0001;
    #1 chk("f_c1_stall_if", stall_if, 1'b1);
    tick();
    chk("f_c2_mem_en", mem_en, 1'b1);
    chk("f_c2_addr", mem_addr, 32'h0000_0010);
    chk("f_c2_we", mem_we, 1'b0);
    chk("f_c2_stall_if", stall_if, 1'b1);
    tick();
    chk("f_c3_ack", if_ack, 1'b1);
    chk("f_c3_rdata", if_rdata, 32'hCAFE_0001);
    chk("f_c3_stall_if", stall_if, 1'b0);
    if_req = 1'b0;
    tick();
    chk("f_c4_ack", if_ack, 1'b0);

    // Simultaneous requests: data first, then fetch after one IDLE cycle.
    if_req = 1'b1; if_addr = 32'h0000_0200;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0100; dm_wdata = 32'hDEAD_BEEF;
    mem_rdata = 32'h0BAD_F00D;
    tick();
    chk("s_d_en_we", {mem_en, mem_we}, 2'b11);
    chk("s_d_addr", mem_addr, 32'h0000_0100);
    chk("s_d_wdata", mem_wdata, 32'hDEAD_BEEF);
    tick();
    chk("s_d_ack_idle", {dm_ack, mem_en}, 2'b10);
    dm_req = 1'b0;
    tick();
    chk("s_i_en_we", {mem_en, mem_we}, 2'b10);
    chk("s_i_addr", mem_addr, 32'h0000_0200);
    tick();
    chk("s_i_ack", if_ack, 1'b1);
    if_req = 1'b0;
    tick();

    // Wait states in BUSY_D.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0300; dm_wdata = 32'h1234_5678;
    mem_ready = 1'b0; ack_cnt = 0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("w_addr", mem_addr, 32'h0000_0300);
      chk("w_wdata", mem_wdata, 32'h1234_5678);
      chk("w_stall_mem", stall_mem, 1'b1);
      mem_rdata = 32'h7700_0000 + i;
      if (i < 4) tick();
    end
    mem_ready = 1'b1; mem_rdata = 32'h5151_2929;
    tick();
    chk("w_ack", dm_ack, 1'b1);
    chk("w_rdata", dm_rdata, 32'h5151_2929);
    dm_req = 1'b0;
    tick(); tick();
    chk("w_ack_once", ack_cnt, 1);

    // Continuous contention: grant order.
    reset = 1'b1; tick(); reset = 1'b0;
    dm_req = 1'b1; if_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0100;
    if_addr = 32'h0000_0200; mem_ready = 1'b1; mem_rdata = 32'hA5A5_0030;
    grant_log = '0; prev_en = mem_en;
    for (int i = 0; i < 16; i++) tick();
    chk("order", grant_log, GUARD ? 64'h4444_4449_4444_4449 : 64'h4444_4444_4444_4444);
    dm_req = 1'b0; if_req = 1'b0;
    tick(); tick();
    chk("pre_rst_rdata_nz", (dm_rdata != 32'h0), 1'b1);

    // Reset wins over mem_ready while in BUSY_D.
    dm_req = 1'b1; dm_addr = 32'h0000_0400; mem_ready = 1'b0;
    tick();
    chk("r_busy", mem_en, 1'b1);
    reset = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h1111_1111;
    tick();
    chk("r_mem_en", mem_en, 1'b0);
    chk("r_dm_ack", dm_ack, 1'b0);
    chk("r_dm_rdata", dm_rdata, 32'h0);
    reset = 1'b0; dm_req = 1'b0;
    tick();
    chk("r_no_late_ack", dm_ack, 1'b0);

    // Requester drops dm_req mid-transaction.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0500; dm_wdata = 32'h5555_AAAA;
    mem_ready = 1'b0;
    tick();
    dm_req = 1'b0; ack_cnt = 0;
    #1 chk("d_no_stall", stall_mem, 1'b0);
    tick(); tick();
    chk("d_still_busy", mem_en, 1'b1);
    mem_ready = 1'b1; mem_rdata = 32'h0DD0_0DD0;
    tick();
    chk("d_ack", dm_ack, 1'b1);
    tick(); tick();
    chk("d_ack_once", ack_cnt, 1);
    chk("d_idle", mem_en, 1'b0);

    // Randomized traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      reset     = ($urandom_range(0, 99) == 0);
      if_req    = 1'($urandom_range(0, 1));
      dm_req    = 1'($urandom_range(0, 1));
      dm_we     = 1'($urandom_range(0, 1));
      if_addr   = $urandom();
      dm_addr   = $urandom();
      dm_wdata  = $urandom();
      mem_rdata = $urandom();
      mem_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_mipspipe_memarb
